// File: rtl/fp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_pkg : shared constants and types for the FP result stage
// Rev 1.0
// ---------------------------------------------------------------------------
package fp_pkg;

    localparam logic [31:0] QNAN         = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
    localparam int          FLAG_W       = 3;
    localparam int          FLAG_UNF     = 0;
    localparam int          FLAG_OVF     = 1;
    localparam int          FLAG_EXC     = 2;
    localparam int          DEPTH        = 2;

    typedef struct packed {
        logic [31:0]       result;
        logic [FLAG_W-1:0] flags;
    } fifo_entry_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_special_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_special_sel : resolves a raw add/sub result against its status flags
// Rev 1.0
// ---------------------------------------------------------------------------
module fp_special_sel
    import fp_pkg::*;
(
    input  logic [31:0] result_i,
    input  logic        exception_i,
    input  logic        overflow_i,
    input  logic        underflow_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = result_i;
        if (exception_i) begin
            result_o = QNAN;
        end else if (overflow_i) begin
            result_o = {result_i[31], EXP_ALL_ONES, 23'h0};
        end else if (underflow_i) begin
            result_o = {result_i[31], 31'h0};
        end
    end

endmodule : fp_special_sel
`default_nettype wire

// File: rtl/fp_result_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_result_stage : special-case substitution, 2-entry output FIFO,
//                   sticky status flags and delivered-result counter
// Rev 1.0
// ---------------------------------------------------------------------------
module fp_result_stage
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_result,
    input  logic              in_overflow,
    input  logic              in_underflow,
    input  logic              in_exception,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [FLAG_W-1:0] out_flags,
    output logic [FLAG_W-1:0] sticky_flags,
    input  logic              clr_flags,
    output logic [15:0]       result_count
);

    fifo_entry_t       mem_q [DEPTH];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              ready_en_q;
    logic [FLAG_W-1:0] sticky_q, sticky_d;
    logic [15:0]       res_cnt_q, res_cnt_d;

    logic [31:0]       w_resolved;
    logic [FLAG_W-1:0] w_in_flags;
    logic              w_accept;
    logic              w_deliver;

    fp_special_sel u_special_sel (
        .result_i    (in_result),
        .exception_i (in_exception),
        .overflow_i  (in_overflow),
        .underflow_i (in_underflow),
        .result_o    (w_resolved)
    );

    always_comb begin
        w_in_flags           = '0;
        w_in_flags[FLAG_EXC] = in_exception;
        w_in_flags[FLAG_OVF] = in_overflow;
        w_in_flags[FLAG_UNF] = in_underflow;
    end

    // ready_en_q keeps in_ready low until the first edge after reset release
    assign in_ready  = ready_en_q & (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign w_accept  = in_valid & in_ready;
    assign w_deliver = out_valid & out_ready;

    assign out_result   = out_valid ? mem_q[rd_ptr_q].result : 32'h0;
    assign out_flags    = out_valid ? mem_q[rd_ptr_q].flags  : '0;
    assign sticky_flags = sticky_q;
    assign result_count = res_cnt_q;

    always_comb begin
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q ^ w_deliver;
        wr_ptr_d  = wr_ptr_q ^ w_accept;
        res_cnt_d = w_deliver ? res_cnt_q + 16'd1 : res_cnt_q;
        unique case ({w_accept, w_deliver})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // an accepted flag survives a same-cycle clear
        sticky_d = (clr_flags ? '0 : sticky_q) | (w_accept ? w_in_flags : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            ready_en_q <= 1'b0;
            sticky_q   <= '0;
            res_cnt_q  <= 16'h0;
        end else begin
            if (w_accept) begin
                mem_q[wr_ptr_q] <= '{result: w_resolved, flags: w_in_flags};
            end
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ready_en_q <= 1'b1;
            sticky_q   <= sticky_d;
            res_cnt_q  <= res_cnt_d;
        end
    end

endmodule : fp_result_stage
`default_nettype wire

// File: tb/tb_fp_result_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fp_result_stage : table vectors, directed corner sequences and random
//                      traffic against a queue-based reference model
// ---------------------------------------------------------------------------
module tb_fp_result_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = '0;
    logic        in_overflow = 1'b0;
    logic        in_underflow = 1'b0;
    logic        in_exception = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [2:0]  out_flags;
    logic [2:0]  sticky_flags;
    logic        clr_flags = 1'b0;
    logic [15:0] result_count;

    fp_result_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .in_exception (in_exception),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .clr_flags    (clr_flags),
        .result_count (result_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: queue of {resolved result, flags}
    logic [34:0] mq[$];
    logic        m_ren    = 1'b0;
    logic [2:0]  m_sticky = '0;
    logic [15:0] m_count  = '0;
    int          n_del    = 0;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;   // {exc, ovf, unf}
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[10];

    function automatic logic [31:0] resolve(input logic [31:0] r, input logic [2:0] f);
        if (f[2])      return 32'h7FC0_0000;
        else if (f[1]) return r[31] ? 32'hFF80_0000 : 32'h7F80_0000;
        else if (f[0]) return r[31] ? 32'h8000_0000 : 32'h0000_0000;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [34:0] head;
        head = (mq.size() > 0) ? mq[0] : 35'h0;
        chk("in_ready",     {31'h0, in_ready},  {31'h0, (m_ren && mq.size() < 2)});
        chk("out_valid",    {31'h0, out_valid}, {31'h0, (mq.size() > 0)});
        chk("out_result",   out_result,         head[34:3]);
        chk("out_flags",    {29'h0, out_flags}, {29'h0, head[2:0]});
        chk("sticky_flags", {29'h0, sticky_flags}, {29'h0, m_sticky});
        chk("result_count", {16'h0, result_count}, {16'h0, m_count});
    endtask

    task automatic model_reset();
        mq.delete();
        m_ren    = 1'b0;
        m_sticky = '0;
        m_count  = '0;
    endtask

    // called at a negedge: drive inputs, advance model, then check after the edge
    task automatic cyc(input logic v, input logic [31:0] r, input logic [2:0] f,
                       input logic ordy, input logic clr);
        logic acc, del;
        in_valid     = v;
        in_result    = r;
        in_exception = f[2];
        in_overflow  = f[1];
        in_underflow = f[0];
        out_ready    = ordy;
        clr_flags    = clr;
        acc = v && m_ren && (mq.size() < 2);
        del = ordy && (mq.size() > 0);
        if (del) begin
            void'(mq.pop_front());
            m_count++;
            n_del++;
        end
        if (acc) mq.push_back({resolve(r, f), f});
        m_sticky = (clr ? 3'b000 : m_sticky) | (acc ? f : 3'b000);
        m_ren    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [2:0] rf;

        tbl[0] = '{32'h4049_0FDB, 3'b000, 32'h4049_0FDB};
        tbl[1] = '{32'hC000_0000, 3'b011, 32'hFF80_0000};
        tbl[2] = '{32'hC000_0000, 3'b111, 32'h7FC0_0000};
        tbl[3] = '{32'h3F80_0000, 3'b001, 32'h0000_0000};
        tbl[4] = '{32'h8000_0001, 3'b001, 32'h8000_0000};
        tbl[5] = '{32'h3F80_0000, 3'b010, 32'h7F80_0000};
        tbl[6] = '{32'h3F80_0000, 3'b100, 32'h7FC0_0000};
        tbl[7] = '{32'hFFFF_FFFF, 3'b100, 32'h7FC0_0000};
        tbl[8] = '{32'h3F80_0000, 3'b101, 32'h7FC0_0000};
        tbl[9] = '{32'hBF80_0000, 3'b110, 32'h7FC0_0000};

        // reset state while rst is held
        #3;
        model_reset();
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();
        cyc(0, 0, 0, 1, 0);

        // table-driven substitution
        for (int i = 0; i < 10; i++) begin
            cyc(1, tbl[i].res, tbl[i].flg, 1, 0);
            chk("tbl_result", out_result, tbl[i].exp);
            chk("tbl_flags", {29'h0, out_flags}, {29'h0, tbl[i].flg});
        end
        cyc(0, 0, 0, 1, 0);
        chk("tbl_count", {16'h0, result_count}, 32'd10);

        // sticky: clear, set, clear-with-accept, clear alone
        cyc(0, 0, 0, 1, 1);
        chk("sticky_clr0", {29'h0, sticky_flags}, 32'h0);
        cyc(1, 32'h3F80_0000, 3'b001, 1, 0);
        chk("sticky_unf", {29'h0, sticky_flags}, 32'h1);
        cyc(1, 32'h4000_0000, 3'b010, 1, 1);
        chk("sticky_clr_acc", {29'h0, sticky_flags}, 32'h2);
        cyc(0, 0, 0, 1, 1);
        chk("sticky_clr1", {29'h0, sticky_flags}, 32'h0);
        cyc(0, 0, 0, 1, 0);

        // backpressure: three offers, two accepted
        cyc(1, 32'h1111_1111, 3'b000, 0, 0);
        cyc(1, 32'h2222_2222, 3'b000, 0, 0);
        chk("bp_ready_low", {31'h0, in_ready}, 32'h0);
        cyc(1, 32'h3333_3333, 3'b000, 0, 0);
        chk("bp_head_hold", out_result, 32'h1111_1111);
        cyc(0, 0, 0, 1, 0);
        chk("bp_second", out_result, 32'h2222_2222);
        cyc(0, 0, 0, 1, 0);
        chk("bp_empty", {31'h0, out_valid}, 32'h0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rf = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            cyc(1'($urandom_range(0, 1)), $urandom, rf,
                1'($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end

        // asynchronous reset with a full buffer
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 32'hAAAA_AAAA, 3'b111, 0, 0);
        cyc(1, 32'hBBBB_BBBB, 3'b000, 0, 0);
        chk("pre_rst_full", {31'h0, in_ready}, 32'h0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        check_all();
        cyc(1, 32'hCCCC_CCCC, 3'b000, 1, 0);
        chk("post_rst_no_accept", {31'h0, out_valid}, 32'h0);

        // counter wrap: exactly 65536 deliveries from zero
        n_del = 0;
        while (n_del < 65536) begin
            cyc(1, $urandom, 3'b000, 1, 0);
        end
        chk("wrap_count", {16'h0, result_count}, 32'h0);

        cyc(0, 0, 0, 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fp_result_stage
`default_nettype wire
